pool_window_gen: RTL and testbench

//   Producer side of the 2x2 max-pool interface. Accepts a raster-scan stream of

---
 rtl/pool_window_gen.sv | 123 ++++++++++++
 tb/tb_pool_window_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window generator feeding the max-pool unit from a raster pixel stream.
// Optional WIN_ZERO_IDLE_EN: win1..win4 read 0 whenever win_en is low (otherwise hold last window).
module pool_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_en,
  input  logic              frame_clr,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic              win_en,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  generate
    if ((IMG_W % 2 != 0) || (IMG_W < 2) || (IMG_H % 2 != 0) || (IMG_H < 2)) begin : g_bad_dims
      $error("pool_window_gen: IMG_W and IMG_H must be even and >= 2");
    end
  endgenerate

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] win1_q, win1_d, win2_q, win2_d, win3_q, win3_d, win4_q, win4_d;
  logic              win_en_q, win_en_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] linebuf_q [IMG_W];
  logic              lb_we;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    lb_we        = 1'b0;
    win_en_d     = 1'b0;
    frame_done_d = 1'b0;
`ifdef WIN_ZERO_IDLE_EN
    win1_d = '0;
    win2_d = '0;
    win3_d = '0;
    win4_d = '0;
`else
    win1_d = win1_q;
    win2_d = win2_q;
    win3_d = win3_q;
    win4_d = win4_q;
`endif
    // frame_clr takes priority: a pixel presented alongside it is discarded
    if (frame_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (pix_en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Even rows fill the line buffer; odd rows pair up with it
      if (!row_q[0]) begin
        lb_we = 1'b1;
      end else if (!col_q[0]) begin
        hold_d = pix_in;
      end else begin
        win1_d       = linebuf_q[col_q - CW'(1)];
        win2_d       = linebuf_q[col_q];
        win3_d       = hold_q;
        win4_d       = pix_in;
        win_en_d     = 1'b1;
        frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      win3_q       <= '0;
      win4_q       <= '0;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win1_q       <= win1_d;
      win2_q       <= win2_d;
      win3_q       <= win3_d;
      win4_q       <= win4_d;
      win_en_q     <= win_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel storage carries no reset; every location is rewritten before it is read
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
    if (lb_we) linebuf_q[col_q] <= pix_in;
  end

  assign win1       = win1_q;
  assign win2       = win2_q;
  assign win3       = win3_q;
  assign win4       = win4_q;
  assign win_en     = win_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (col_q != '0) || (row_q != '0);

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen on a 4x4 frame: table vectors for the basic frame,
// then model-checked sequences (gaps, back-to-back, frame_clr, async reset, random).
module tb_pool_window_gen;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef WIN_ZERO_IDLE_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_en = 1'b0;
  logic          frame_clr = 1'b0;
  logic [DW-1:0] win1, win2, win3, win4;
  logic          win_en, frame_done, busy;

  pool_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_en(pix_en), .frame_clr(frame_clr),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4),
    .win_en(win_en), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int fd_seen = 0;

  // Reference model: whole frame image indexed by a linear pixel count
  int            pos;
  logic [DW-1:0] img [H][W];
  logic [DW-1:0] last [4];
  logic [DW-1:0] e_w [4];
  logic          e_en, e_fd, e_busy;

  typedef struct {
    logic [DW-1:0] pix;
    logic          x_en;
    logic          x_fd;
    logic          x_busy;
    logic [DW-1:0] x1, x2, x3, x4;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int k = 0; k < 4; k++) last[k] = '0;
  endtask

  task automatic predict(input logic [DW-1:0] p, input logic en, input logic clr);
    int r, c;
    e_en = 1'b0;
    e_fd = 1'b0;
    if (clr) begin
      pos = 0;
    end else if (en) begin
      r = pos / W;
      c = pos % W;
      img[r][c] = p;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e_en    = 1'b1;
        last[0] = img[r-1][c-1];
        last[1] = img[r-1][c];
        last[2] = img[r][c-1];
        last[3] = p;
        e_fd    = (pos == W*H - 1);
      end
      pos = (pos + 1) % (W*H);
    end
    e_busy = (pos != 0);
    for (int k = 0; k < 4; k++) e_w[k] = (e_en || !ZERO) ? last[k] : '0;
  endtask

  task automatic check_outputs();
    chk("win1", 64'(win1), 64'(e_w[0]));
    chk("win2", 64'(win2), 64'(e_w[1]));
    chk("win3", 64'(win3), 64'(e_w[2]));
    chk("win4", 64'(win4), 64'(e_w[3]));
    chk("win_en", 64'(win_en), 64'(e_en));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("busy", 64'(busy), 64'(e_busy));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_win1"}, 64'(win1), 64'd0);
    chk({nm, "_win2"}, 64'(win2), 64'd0);
    chk({nm, "_win3"}, 64'(win3), 64'd0);
    chk({nm, "_win4"}, 64'(win4), 64'd0);
    chk({nm, "_win_en"}, 64'(win_en), 64'd0);
    chk({nm, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic drive(input logic [DW-1:0] p, input logic en, input logic clr);
    pix_in    = p;
    pix_en    = en;
    frame_clr = clr;
    predict(p, en, clr);
    @(posedge clk);
    #1;
    check_outputs();
    if (win_en === 1'b1 && frame_done === 1'b1) fd_seen++;
  endtask

  task automatic frame(input int base, input int n);
    for (int i = 0; i < n; i++) drive(DW'(base + i), 1'b1, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] cur [4];
    model_reset();

    // Reset state
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: table of one full frame, pix_en held high
    for (int k = 0; k < 4; k++) cur[k] = '0;
    for (int i = 0; i < 16; i++) begin
      case (i)
        5:  begin cur[0] = 0;  cur[1] = 1;  cur[2] = 4;  cur[3] = 5;  end
        7:  begin cur[0] = 2;  cur[1] = 3;  cur[2] = 6;  cur[3] = 7;  end
        13: begin cur[0] = 8;  cur[1] = 9;  cur[2] = 12; cur[3] = 13; end
        15: begin cur[0] = 10; cur[1] = 11; cur[2] = 14; cur[3] = 15; end
        default: ;
      endcase
      tbl[i].pix    = DW'(i);
      tbl[i].x_en   = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      tbl[i].x_fd   = (i == 15);
      tbl[i].x_busy = (i != 15);
      tbl[i].x1     = (tbl[i].x_en || !ZERO) ? cur[0] : '0;
      tbl[i].x2     = (tbl[i].x_en || !ZERO) ? cur[1] : '0;
      tbl[i].x3     = (tbl[i].x_en || !ZERO) ? cur[2] : '0;
      tbl[i].x4     = (tbl[i].x_en || !ZERO) ? cur[3] : '0;
    end
    for (int i = 0; i < 16; i++) begin
      pix_in    = tbl[i].pix;
      pix_en    = 1'b1;
      frame_clr = 1'b0;
      predict(tbl[i].pix, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("t1_win1", 64'(win1), 64'(tbl[i].x1));
      chk("t1_win2", 64'(win2), 64'(tbl[i].x2));
      chk("t1_win3", 64'(win3), 64'(tbl[i].x3));
      chk("t1_win4", 64'(win4), 64'(tbl[i].x4));
      chk("t1_win_en", 64'(win_en), 64'(tbl[i].x_en));
      chk("t1_frame_done", 64'(frame_done), 64'(tbl[i].x_fd));
      chk("t1_busy", 64'(busy), 64'(tbl[i].x_busy));
    end
    // Idle after the last window: zero or hold depending on build
    drive('0, 1'b0, 1'b0);
    drive(16'h5a5a, 1'b0, 1'b0);

    // Test 2: three idle cycles between pixels
    for (int i = 0; i < 16; i++) begin
      drive(DW'(i), 1'b1, 1'b0);
      repeat (3) drive(DW'($urandom), 1'b0, 1'b0);
    end

    // Test 3: two frames back-to-back
    fd_seen = 0;
    frame(0, 16);
    frame(100, 16);
    chk("t3_frame_done_count", 64'(fd_seen), 64'd2);

    // Test 4: partial frame, frame_clr with a competing pixel, then a clean frame
    frame(0, 7);
    drive(DW'(99), 1'b1, 1'b1);
    chk("t4_busy_after_clr", 64'(busy), 64'd0);
    frame(0, 16);

    // Test 5: async reset right after pixel 5's window
    frame(0, 6);
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    @(posedge clk);
    #1;
    check_zero("t5_held");
    rst_n = 1'b1;
    model_reset();
    frame(0, 16);

    // Randomized traffic with occasional frame_clr
    for (int i = 0; i < 500; i++)
      drive(DW'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));

    pix_en = 1'b0;
    frame_clr = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
